// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM state type and sizing helpers for the row convolution engine.
package conv_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_MAC, S_POST, S_WRITE, S_SHIFT, S_DONE} state_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
  function automatic int acc_min_w(input int bd, input int k);
    return 2 * bd + clog2(k * k) + 1;
  endfunction
  function automatic int stride_clamp(input int s, input int max_s);
    return (s == 0) ? 1 : (s > max_s) ? max_s : s;
  endfunction
endpackage

// File: rtl/conv_row_engine_if.sv
// conv_row_engine_if: column input stream and result output stream of conv_row_engine.
// master = engine side (accepts columns, produces results); slave = surrounding pipeline.
interface conv_row_engine_if import conv_pkg::*; #(
  parameter int BIT_DEPTH = 8,
  parameter int K = 3,
  parameter int IMG_W = 28,
  parameter int ACC_W = 24
);
  logic col_valid;
  logic col_ready;
  logic [K*BIT_DEPTH-1:0] col_data;
  logic out_valid;
  logic out_ready;
  logic [BIT_DEPTH-1:0] out_data;
  logic signed [ACC_W-1:0] acc_out;
  logic [clog2(IMG_W)-1:0] out_idx;
  modport master (
    input col_valid, col_data, out_ready,
    output col_ready, out_valid, out_data, acc_out, out_idx
  );
  modport slave (
    output col_valid, col_data, out_ready,
    input col_ready, out_valid, out_data, acc_out, out_idx
  );
endinterface

// File: rtl/conv_col_window.sv
// conv_col_window: KxK pixel window; shift_en pushes col_in in as the newest column (K-1).
// Ports: clk/rst, shift_en, col_in (row r at [r*BIT_DEPTH +: BIT_DEPTH]), rd_row/rd_col -> rd_pix.
module conv_col_window import conv_pkg::*; #(
  parameter int BIT_DEPTH = 8,
  parameter int K = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic shift_en,
  input  logic [K*BIT_DEPTH-1:0] col_in,
  input  logic [clog2(K)-1:0] rd_row,
  input  logic [clog2(K)-1:0] rd_col,
  output logic [BIT_DEPTH-1:0] rd_pix
);
  logic [BIT_DEPTH-1:0] win [K][K];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win[r][c] <= '0;
    end else if (shift_en) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win[r][c] <= win[r][c+1];
        win[r][K-1] <= col_in[r*BIT_DEPTH +: BIT_DEPTH];
      end
    end
  end
  assign rd_pix = win[rd_row][rd_col];
endmodule

// File: rtl/conv_row_engine.sv
// conv_row_engine: one output row of a KxK convolution over a streamed column strip.
// Ports: clk/rst, start/stride/shift_amt (row control, sampled at start),
// w_wr_en/w_addr/w_data (kernel load, IDLE only), busy/done status, bus (column in, result out).
module conv_row_engine import conv_pkg::*; #(
  parameter int BIT_DEPTH = 8,
  parameter int K = 3,
  parameter int IMG_W = 28,
  parameter int MAX_STRIDE = 4,
  parameter int ACC_W = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [clog2(MAX_STRIDE+1)-1:0] stride,
  input  logic [4:0] shift_amt,
  input  logic w_wr_en,
  input  logic [clog2(K*K)-1:0] w_addr,
  input  logic [BIT_DEPTH-1:0] w_data,
  output logic busy,
  output logic done,
  conv_row_engine_if.master bus
);
  localparam int SW = clog2(MAX_STRIDE + 1);
  localparam int CW = clog2(IMG_W + 1);
  localparam int KW = clog2(K);
  localparam int WA = clog2(K * K);
  localparam int IW = clog2(IMG_W);
  localparam int PW = 2 * BIT_DEPTH + 1;
  state_t state, nxt;
  logic signed [BIT_DEPTH-1:0] w [K*K];
  logic [SW-1:0] stride_q, sh_cnt;
  logic [4:0] shift_q;
  logic [CW-1:0] col_cnt;
  logic [KW-1:0] mr, mc;
  logic [WA-1:0] widx;
  logic signed [ACC_W-1:0] acc, acc_sh;
  logic [BIT_DEPTH-1:0] pix, q;
  logic signed [PW-1:0] pix_s, w_s, prod;
  logic xfer, mac_last, fits;
  conv_col_window #(.BIT_DEPTH(BIT_DEPTH), .K(K)) u_win (
    .clk(clk),
    .rst(rst),
    .shift_en(xfer),
    .col_in(bus.col_data),
    .rd_row(mr),
    .rd_col(mc),
    .rd_pix(pix)
  );
  assign xfer = bus.col_valid & bus.col_ready;
  assign mac_last = (mr == KW'(K - 1)) && (mc == KW'(K - 1));
  assign fits = int'(col_cnt) + int'(stride_q) <= IMG_W;
  // pixels are unsigned, so zero-extend before the signed multiply
  assign pix_s = PW'({1'b0, pix});
  assign w_s = PW'(w[widx]);
  assign prod = pix_s * w_s;
  // negative results clamp to 0 (ReLU), oversized ones saturate
  assign acc_sh = acc >>> shift_q;
  assign q = acc_sh[ACC_W-1] ? '0 : (|acc_sh[ACC_W-2:BIT_DEPTH]) ? '1 : acc_sh[BIT_DEPTH-1:0];
  assign bus.col_ready = state == S_FILL || state == S_SHIFT;
  assign bus.out_valid = state == S_WRITE;
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  always_ff @(posedge clk) state <= rst ? S_IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = start ? S_FILL : S_IDLE;
      S_FILL:  nxt = (xfer && col_cnt == CW'(K - 1)) ? S_MAC : S_FILL;
      S_MAC:   nxt = mac_last ? S_POST : S_MAC;
      S_POST:  nxt = S_WRITE;
      S_WRITE: nxt = !bus.out_ready ? S_WRITE : fits ? S_SHIFT : S_DONE;
      S_SHIFT: nxt = (xfer && sh_cnt == stride_q - SW'(1)) ? S_MAC : S_SHIFT;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < K * K; i++) w[i] <= '0;
      stride_q <= SW'(1);
      shift_q <= '0;
      col_cnt <= '0;
      sh_cnt <= '0;
      mr <= '0;
      mc <= '0;
      widx <= '0;
      acc <= '0;
      bus.out_data <= '0;
      bus.acc_out <= '0;
      bus.out_idx <= '0;
    end else begin
      if (state == S_IDLE && w_wr_en && int'(w_addr) < K * K) w[w_addr] <= w_data;
      if (state == S_IDLE && start) begin
        stride_q <= SW'(stride_clamp(int'(stride), MAX_STRIDE));
        shift_q <= shift_amt;
        col_cnt <= '0;
        bus.out_idx <= '0;
      end
      if (xfer) col_cnt <= col_cnt + CW'(1);
      sh_cnt <= (state == S_SHIFT) ? sh_cnt + SW'(xfer) : '0;
      // holding the MAC state at zero outside MAC clears it on every entry
      if (state != S_MAC) begin
        acc <= '0;
        mr <= '0;
        mc <= '0;
        widx <= '0;
      end else begin
        acc <= acc + ACC_W'(prod);
        widx <= widx + WA'(1);
        mc <= (mc == KW'(K - 1)) ? '0 : mc + KW'(1);
        mr <= (mc == KW'(K - 1)) ? mr + KW'(1) : mr;
      end
      if (state == S_POST) begin
        bus.acc_out <= acc;
        bus.out_data <= q;
      end
      if (state == S_WRITE && bus.out_ready) bus.out_idx <= bus.out_idx + IW'(1);
    end
  end
endmodule

// File: tb/tb_conv_row_engine.sv
// tb_conv_row_engine: scoreboard bench for conv_row_engine (K=3, IMG_W=8).
module tb_conv_row_engine;
  localparam int BD = 8;
  localparam int K = 3;
  localparam int IMG_W = 8;
  localparam int MS = 4;
  localparam int AW = 24;
  typedef struct {
    logic [BD-1:0] d;
    logic signed [AW-1:0] a;
    int idx;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  logic start = 0;
  logic w_wr_en = 0;
  logic [2:0] stride = 0;
  logic [4:0] shift_amt = 0;
  logic [3:0] w_addr = 0;
  logic [7:0] w_data = 0;
  logic busy, done;
  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int img [IMG_W][K];
  int wtb [K*K];
  exp_t sb [$];
  conv_row_engine_if #(.BIT_DEPTH(BD), .K(K), .IMG_W(IMG_W), .ACC_W(AW)) bus ();
  conv_row_engine #(.BIT_DEPTH(BD), .K(K), .IMG_W(IMG_W), .MAX_STRIDE(MS), .ACC_W(AW)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stride(stride),
    .shift_amt(shift_amt),
    .w_wr_en(w_wr_en),
    .w_addr(w_addr),
    .w_data(w_data),
    .busy(busy),
    .done(done),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (done) done_cnt++;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic fill_img(input bit rnd, input int v);
    for (int c = 0; c < IMG_W; c++)
      for (int r = 0; r < K; r++) img[c][r] = rnd ? int'($urandom_range(0, 255)) : v;
  endtask
  task automatic load_weights(input bit rnd, input int v);
    for (int i = 0; i < K * K; i++) begin
      wtb[i] = rnd ? int'($urandom_range(0, 255)) - 128 : v;
      w_wr_en = 1;
      w_addr = 4'(i);
      w_data = 8'(wtb[i]);
      tick;
    end
    w_wr_en = 0;
  endtask
  function automatic exp_t model(input int j, input int sc, input int sh);
    exp_t e;
    int sum = 0;
    logic signed [AW-1:0] a, s;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) sum += img[j*sc+c][r] * wtb[r*K+c];
    a = AW'(sum);
    s = a >>> sh;
    e.a = a;
    e.d = (s < 0) ? 8'd0 : (s > 255) ? 8'd255 : s[7:0];
    e.idx = j;
    return e;
  endfunction
  task automatic run_row(input int s, input int sh, input int stall, input bit poke, input string name);
    int sc, n, ncols, d0, taken;
    sc = (s == 0) ? 1 : (s > MS) ? MS : s;
    n = (IMG_W - K) / sc + 1;
    ncols = K + (n - 1) * sc;
    for (int j = 0; j < n; j++) sb.push_back(model(j, sc, sh));
    d0 = done_cnt;
    taken = 0;
    stride = 3'(s);
    shift_amt = 5'(sh);
    start = 1;
    tick;
    start = 0;
    fork
      begin
        int col = 0;
        int g = 0;
        bit rdy;
        while (busy && g < 3000) begin
          bus.col_valid = col < IMG_W;
          bus.col_data = '0;
          if (col < IMG_W)
            for (int r = 0; r < K; r++) bus.col_data[r*BD +: BD] = 8'(img[col][r]);
          rdy = bus.col_valid && bus.col_ready;
          tick;
          g++;
          if (rdy) col++;
        end
        bus.col_valid = 0;
        taken = col;
      end
      begin
        for (int j = 0; j < n; j++) begin
          exp_t e;
          int g = 0;
          while (!bus.out_valid && g < 500) begin
            tick;
            g++;
          end
          vectors++;
          if (!bus.out_valid) begin
            miscompares++;
            $display("FAIL %s out_valid timeout at output %0d", name, j);
            break;
          end
          e = sb.pop_front();
          vectors++;
          if (bus.out_data !== e.d) begin
            miscompares++;
            $display("FAIL %s out_data[%0d]: got %0d want %0d", name, j, bus.out_data, e.d);
          end
          vectors++;
          if (bus.acc_out !== e.a) begin
            miscompares++;
            $display("FAIL %s acc_out[%0d]: got %0d want %0d", name, j, bus.acc_out, e.a);
          end
          vectors++;
          if (bus.out_idx !== 3'(e.idx)) begin
            miscompares++;
            $display("FAIL %s out_idx[%0d]: got %0d want %0d", name, j, bus.out_idx, e.idx);
          end
          if (j == 0)
            for (int k = 0; k < stall; k++) begin
              tick;
              vectors++;
              if (!(bus.out_valid === 1'b1 && bus.out_data === e.d && bus.out_idx === 3'(e.idx) && bus.col_ready === 1'b0)) begin
                miscompares++;
                $display("FAIL %s stall hold cycle %0d: valid=%b data=%0d idx=%0d col_ready=%b want 1/%0d/%0d/0",
                         name, k, bus.out_valid, bus.out_data, bus.out_idx, bus.col_ready, e.d, e.idx);
              end
            end
          bus.out_ready = 1;
          tick;
          bus.out_ready = 0;
          vectors++;
          if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s out_valid after handshake %0d: got %b want 0", name, j, bus.out_valid);
          end
        end
      end
      begin
        if (poke) begin
          repeat (6) tick;
          start = 1;
          w_wr_en = 1;
          w_addr = 4'd4;
          w_data = 8'd7;
          tick;
          start = 0;
          w_wr_en = 0;
        end
      end
    join
    sb.delete();
    vectors++;
    if (taken != ncols) begin
      miscompares++;
      $display("FAIL %s columns accepted: got %0d want %0d", name, taken, ncols);
    end
    vectors++;
    if (done_cnt != d0 + 1) begin
      miscompares++;
      $display("FAIL %s done pulses: got %0d want 1", name, done_cnt - d0);
    end
    vectors++;
    if (bus.out_idx !== 3'(n) || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s end state: out_idx=%0d busy=%b want %0d/0", name, bus.out_idx, busy, n);
    end
  endtask
  task automatic check_zero(input string name);
    vectors++;
    if ({busy, done, bus.col_ready, bus.out_valid} !== 4'b0 || bus.out_data !== '0 || bus.acc_out !== '0 || bus.out_idx !== '0) begin
      miscompares++;
      $display("FAIL %s outputs: busy=%b done=%b col_ready=%b out_valid=%b out_data=%0d acc_out=%0d out_idx=%0d want all 0",
               name, busy, done, bus.col_ready, bus.out_valid, bus.out_data, bus.acc_out, bus.out_idx);
    end
  endtask
  task automatic test_reset;
    rst = 1;
    repeat (3) tick;
    check_zero("reset");
    rst = 0;
    tick;
  endtask
  task automatic test_stride1;
    load_weights(0, 1);
    fill_img(0, 1);
    run_row(1, 0, 0, 0, "ones_stride1");
  endtask
  task automatic test_stride2;
    run_row(2, 0, 0, 0, "ones_stride2");
  endtask
  task automatic test_negative;
    load_weights(0, -1);
    fill_img(0, 5);
    run_row(1, 0, 0, 0, "neg_relu");
  endtask
  task automatic test_saturate;
    load_weights(0, 1);
    fill_img(0, 255);
    run_row(1, 0, 0, 0, "sat_shift0");
    run_row(1, 4, 0, 0, "sat_shift4");
  endtask
  task automatic test_backpressure;
    fill_img(0, 1);
    run_row(1, 0, 5, 0, "backpressure");
  endtask
  task automatic test_busy_ignore;
    run_row(1, 0, 0, 1, "busy_ignore");
  endtask
  task automatic test_random;
    load_weights(1, 0);
    fill_img(1, 0);
    run_row(0, int'($urandom_range(0, 6)), 0, 0, "rand_stride0");
    fill_img(1, 0);
    run_row(3, int'($urandom_range(0, 6)), 0, 0, "rand_stride3");
    load_weights(1, 0);
    fill_img(1, 0);
    run_row(7, int'($urandom_range(0, 6)), 0, 0, "rand_stride7");
  endtask
  task automatic test_reset_mid_row;
    int d0, got, g;
    bit rdy;
    load_weights(0, 1);
    fill_img(0, 1);
    d0 = done_cnt;
    got = 0;
    g = 0;
    stride = 1;
    shift_amt = 0;
    start = 1;
    tick;
    start = 0;
    bus.col_valid = 1;
    bus.col_data = {3{8'd1}};
    while (got < K && g < 100) begin
      rdy = bus.col_ready;
      tick;
      g++;
      if (rdy) got++;
    end
    bus.col_valid = 0;
    tick;
    rst = 1;
    tick;
    check_zero("reset_in_mac");
    rst = 0;
    repeat (3) tick;
    vectors++;
    if (done_cnt != d0) begin
      miscompares++;
      $display("FAIL reset_in_mac done pulses: got %0d want 0", done_cnt - d0);
    end
    for (int i = 0; i < K * K; i++) wtb[i] = 0;
    run_row(1, 0, 0, 0, "post_reset_cleared_w");
    load_weights(0, 1);
    run_row(1, 0, 0, 0, "post_reset_run");
  endtask
  initial begin
    bus.col_valid = 0;
    bus.col_data = '0;
    bus.out_ready = 0;
    test_reset;
    test_stride1;
    test_stride2;
    test_negative;
    test_saturate;
    test_backpressure;
    test_busy_ignore;
    test_random;
    test_reset_mid_row;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
